// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM wishbone-style port arbiter.
package sram_arb_pkg;

  // Transaction sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // Master indices into one-hot grant / done vectors
  localparam int M0_IDX = 0;  // VGA line fetch
  localparam int M1_IDX = 1;  // CPU/DMA data path

  // One-hot grant encodings
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/sram_wb_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the SRAM controller.
// The slave modport is the arbiter's view; the master modport is the view of
// the surrounding masters plus SRAM controller that drive and consume it.
interface sram_wb_arbiter_if;
  // Master 0 (read-only fetch)
  logic        m0_stb;
  logic        m0_urgent;
  logic [31:0] m0_addr;
  // Master 1 (read/write)
  logic        m1_stb;
  logic [31:0] m1_addr;
  logic [3:0]  m1_we;
  logic [31:0] m1_din;
  // Completion back to the masters
  logic        m0_done;
  logic        m1_done;
  logic [47:0] m_dout;
  // SRAM controller side
  logic        s_stb;
  logic [31:0] s_addr;
  logic [3:0]  s_we;
  logic [31:0] s_din;
  logic [47:0] s_dout;
  logic        s_nak;

  modport slave (
    input  m0_stb, m0_urgent, m0_addr,
    input  m1_stb, m1_addr, m1_we, m1_din,
    input  s_dout, s_nak,
    output m0_done, m1_done, m_dout,
    output s_stb, s_addr, s_we, s_din
  );

  modport master (
    output m0_stb, m0_urgent, m0_addr,
    output m1_stb, m1_addr, m1_we, m1_din,
    output s_dout, s_nak,
    input  m0_done, m1_done, m_dout,
    input  s_stb, s_addr, s_we, s_din
  );
endinterface

// File: rtl/sram_arb_pick.sv
// Combinational winner selection: urgent M0 first, then forced M0 when the
// M1 run limit is reached, then round-robin, then the lone requester.
module sram_arb_pick
  import sram_arb_pkg::*;
(
  input  logic [1:0] stb,       // {m1_stb, m0_stb}
  input  logic       urgent,    // M0 fetch FIFO running low
  input  logic       run_full,  // M1 has had its maximum run while M0 waited
  input  logic       rr_ptr,    // 0: M0 preferred on a tie, 1: M1 preferred
  output logic [1:0] win        // one-hot winner, 00 when nobody requests
);

  // Priority chain evaluated every cycle; the caller only uses it in IDLE
  always_comb begin
    win = GNT_NONE;
    if (stb[M0_IDX] && urgent) begin
      win = GNT_M0;
    end else if (stb[M0_IDX] && stb[M1_IDX]) begin
      win = (run_full || !rr_ptr) ? GNT_M0 : GNT_M1;
    end else if (stb[M0_IDX]) begin
      win = GNT_M0;
    end else if (stb[M1_IDX]) begin
      win = GNT_M1;
    end
  end

endmodule

// File: rtl/sram_wb_arbiter.sv
// Two-master arbiter for the single SRAM port. One transaction outstanding:
// IDLE (arbitrate, latch request) -> ISSUE (one-cycle s_stb) -> WAIT (until
// s_nak low) -> IDLE. Optional feature macro: SRAM_ARB_TIMEOUT_EN adds a WAIT
// watchdog that aborts the transaction with zero data and a sticky err.
module sram_wb_arbiter
  import sram_arb_pkg::*;
#(
  parameter int MAX_M1_RUN = 4
`ifdef SRAM_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  sram_wb_arbiter_if.slave    bus,
  output logic [1:0]          grant,
  output logic                err
);

  localparam int RUN_W = $clog2(MAX_M1_RUN + 1);

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  done_q, done_d;
  logic        s_stb_q, s_stb_d;
  logic [31:0] s_addr_q, s_addr_d;
  logic [3:0]  s_we_q, s_we_d;
  logic [31:0] s_din_q, s_din_d;
  logic [47:0] m_dout_q, m_dout_d;
  logic        rr_q, rr_d;          // 1: M1 wins the next tie
  logic [RUN_W-1:0] run_q, run_d;   // M1 grants in a row while M0 waited
`ifdef SRAM_ARB_TIMEOUT_EN
  logic [7:0]  tmo_q, tmo_d;
  logic        err_q, err_d;
`endif

  logic [1:0]  win;
  logic        run_full;

  assign run_full = (run_q == RUN_W'(MAX_M1_RUN));

  sram_arb_pick u_pick (
    .stb      ({bus.m1_stb, bus.m0_stb}),
    .urgent   (bus.m0_urgent),
    .run_full (run_full),
    .rr_ptr   (rr_q),
    .win      (win)
  );

  // Next-state and datapath updates for the transaction sequencer
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    done_d   = GNT_NONE;
    s_stb_d  = 1'b0;
    s_addr_d = s_addr_q;
    s_we_d   = s_we_q;
    s_din_d  = s_din_q;
    m_dout_d = m_dout_q;
    rr_d     = rr_q;
    run_d    = run_q;
`ifdef SRAM_ARB_TIMEOUT_EN
    tmo_d    = tmo_q;
    err_d    = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (win != GNT_NONE) begin
          grant_d = win;
          s_stb_d = 1'b1;
          state_d = ST_ISSUE;
          if (win == GNT_M0) begin
            // M0 is a pure reader: never let stale write data through
            s_addr_d = bus.m0_addr;
            s_we_d   = 4'b0000;
            s_din_d  = 32'h0;
            rr_d     = 1'b1;
            run_d    = '0;
          end else begin
            s_addr_d = bus.m1_addr;
            s_we_d   = bus.m1_we;
            s_din_d  = bus.m1_din;
            rr_d     = 1'b0;
            // Only count M1 grants that made a waiting M0 wait longer
            if (!bus.m0_stb) begin
              run_d = '0;
            end else if (!run_full) begin
              run_d = run_q + RUN_W'(1);
            end
          end
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
`ifdef SRAM_ARB_TIMEOUT_EN
        tmo_d   = 8'd0;
`endif
      end
      ST_WAIT: begin
        if (!bus.s_nak) begin
          m_dout_d = bus.s_dout;
          done_d   = grant_q;
          grant_d  = GNT_NONE;
          state_d  = ST_IDLE;
        end
`ifdef SRAM_ARB_TIMEOUT_EN
        else if (tmo_q == 8'(TIMEOUT_CYCLES - 1)) begin
          // Slave is stuck: release the master with empty data
          m_dout_d = 48'h0;
          done_d   = grant_q;
          grant_d  = GNT_NONE;
          err_d    = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = GNT_NONE;
      end
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= GNT_NONE;
      done_q   <= GNT_NONE;
      s_stb_q  <= 1'b0;
      s_addr_q <= 32'h0;
      s_we_q   <= 4'b0000;
      s_din_q  <= 32'h0;
      m_dout_q <= 48'h0;
      rr_q     <= 1'b0;
      run_q    <= '0;
`ifdef SRAM_ARB_TIMEOUT_EN
      tmo_q    <= 8'd0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      s_stb_q  <= s_stb_d;
      s_addr_q <= s_addr_d;
      s_we_q   <= s_we_d;
      s_din_q  <= s_din_d;
      m_dout_q <= m_dout_d;
      rr_q     <= rr_d;
      run_q    <= run_d;
`ifdef SRAM_ARB_TIMEOUT_EN
      tmo_q    <= tmo_d;
      err_q    <= err_d;
`endif
    end
  end

  assign bus.s_stb   = s_stb_q;
  assign bus.s_addr  = s_addr_q;
  assign bus.s_we    = s_we_q;
  assign bus.s_din   = s_din_q;
  assign bus.m_dout  = m_dout_q;
  assign bus.m0_done = done_q[M0_IDX];
  assign bus.m1_done = done_q[M1_IDX];
  assign grant       = grant_q;
`ifdef SRAM_ARB_TIMEOUT_EN
  assign err         = err_q;
`else
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_sram_wb_arbiter.sv
// Bench for sram_wb_arbiter: transaction-level reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_sram_wb_arbiter;

  localparam int MAX_RUN = 4;
  localparam int TMO     = 255;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] grant;
  logic       err;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: one outstanding transaction, tracked by owner and age
  bit          busy;
  bit          past_issue;
  int          owner;
  int          rr;     // master preferred on the next tie
  int          run;    // M1 grants in a row while M0 waited
`ifdef SRAM_ARB_TIMEOUT_EN
  int          nak_cnt;
`endif
  logic        exp_s_stb;
  logic [31:0] exp_s_addr;
  logic [3:0]  exp_s_we;
  logic [31:0] exp_s_din;
  logic [1:0]  exp_grant;
  logic [1:0]  exp_done;
  logic [47:0] exp_dout;
  logic        exp_err;

  int exp_seq3 [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 0, 1};

  sram_wb_arbiter_if bus ();

  sram_wb_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .grant (grant),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: event not seen within its cycle budget (t=%0t)", name, $time);
  endtask

  // Advance the model by one clock edge using the inputs the DUT also sees
  task automatic model_step();
    int w;
    if (!rst_n) begin
      busy = 0; past_issue = 0; owner = 0; rr = 0; run = 0;
`ifdef SRAM_ARB_TIMEOUT_EN
      nak_cnt = 0;
`endif
      exp_s_stb = 0; exp_s_addr = 0; exp_s_we = 0; exp_s_din = 0;
      exp_grant = 0; exp_done = 0; exp_dout = 0; exp_err = 0;
    end else begin
      exp_done  = 2'b00;
      exp_s_stb = 1'b0;
      if (!busy) begin
        w = -1;
        if (bus.m0_stb && bus.m0_urgent)   w = 0;
        else if (bus.m0_stb && bus.m1_stb) w = (run == MAX_RUN) ? 0 : rr;
        else if (bus.m0_stb)               w = 0;
        else if (bus.m1_stb)               w = 1;
        if (w == 0) begin
          exp_s_addr = bus.m0_addr; exp_s_we = 4'h0; exp_s_din = 32'h0;
          exp_grant  = 2'b01;
          run = 0;
        end else if (w == 1) begin
          exp_s_addr = bus.m1_addr; exp_s_we = bus.m1_we; exp_s_din = bus.m1_din;
          exp_grant  = 2'b10;
          run = bus.m0_stb ? ((run < MAX_RUN) ? run + 1 : MAX_RUN) : 0;
        end
        if (w >= 0) begin
          busy = 1; past_issue = 0; owner = w; rr = 1 - w; exp_s_stb = 1'b1;
`ifdef SRAM_ARB_TIMEOUT_EN
          nak_cnt = 0;
`endif
        end
      end else if (!past_issue) begin
        past_issue = 1;
      end else if (!bus.s_nak) begin
        exp_done  = (owner == 0) ? 2'b01 : 2'b10;
        exp_dout  = bus.s_dout;
        exp_grant = 2'b00;
        busy      = 0;
      end
`ifdef SRAM_ARB_TIMEOUT_EN
      else begin
        nak_cnt++;
        if (nak_cnt == TMO) begin
          exp_done  = (owner == 0) ? 2'b01 : 2'b10;
          exp_dout  = 48'h0;
          exp_grant = 2'b00;
          exp_err   = 1'b1;
          busy      = 0;
        end
      end
`endif
    end
  endtask

  task automatic compare_cycle();
    chk("s_stb",   bus.s_stb,   exp_s_stb);
    chk("s_addr",  bus.s_addr,  exp_s_addr);
    chk("s_we",    bus.s_we,    exp_s_we);
    chk("s_din",   bus.s_din,   exp_s_din);
    chk("grant",   grant,       exp_grant);
    chk("m0_done", bus.m0_done, exp_done[0]);
    chk("m1_done", bus.m1_done, exp_done[1]);
    chk("m_dout",  bus.m_dout,  exp_dout);
    chk("err",     err,         exp_err);
    if (bus.m0_done || bus.m1_done)
      $display("txn: m%0d done dout=%h err=%b t=%0t", bus.m1_done ? 1 : 0, bus.m_dout, err, $time);
  endtask

  task automatic wait_done(input int budget, output int who, output int cycles);
    who = -1;
    cycles = 0;
    while (who < 0 && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (bus.m0_done)      who = 0;
      else if (bus.m1_done) who = 1;
    end
    if (who < 0) fail_now("wait_done");
  endtask

  task automatic wait_stb(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.s_stb && n < budget);
    if (!bus.s_stb) fail_now("wait_stb");
  endtask

  initial begin
    int who, cyc, streak;
    bus.m0_stb = 0; bus.m0_urgent = 0; bus.m0_addr = 0;
    bus.m1_stb = 0; bus.m1_addr = 0; bus.m1_we = 0; bus.m1_din = 0;
    bus.s_dout = 0; bus.s_nak = 0;

    fork
      forever begin @(posedge clk); model_step(); end
      forever begin @(negedge clk); compare_cycle(); end
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_grant", grant, 2'b00);
    chk("rst_s_stb", bus.s_stb, 1'b0);
    chk("rst_m_dout", bus.m_dout, 48'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: M1 write with a slow slave
    bus.m1_addr = 32'h100; bus.m1_we = 4'hF; bus.m1_din = 32'hDEADBEEF;
    bus.s_dout = 48'hCAFE_0BAD_F00D; bus.s_nak = 1'b1; bus.m1_stb = 1'b1;
    wait_stb(10);
    chk("t1_s_addr", bus.s_addr, 32'h100);
    chk("t1_s_we",   bus.s_we,   4'hF);
    chk("t1_s_din",  bus.s_din,  32'hDEADBEEF);
    chk("t1_grant",  grant,      2'b10);
    @(negedge clk);
    chk("t1_stb_one_cycle", bus.s_stb, 1'b0);
    repeat (2) @(negedge clk);
    bus.s_nak = 1'b0;
    wait_done(10, who, cyc);
    chk("t1_owner", who, 1);
    chk("t1_latency", cyc, 1);
    chk("t1_dout", bus.m_dout, 48'hCAFE_0BAD_F00D);
    bus.m1_stb = 1'b0;
    @(negedge clk);
    chk("t1_grant_idle", grant, 2'b00);

    // 2: both requesting, zero-wait slave -> strict alternation, 3-cycle period
    bus.m0_addr = 32'h40; bus.m1_addr = 32'h80; bus.m1_we = 4'h3; bus.m1_din = 32'h1234_5678;
    bus.s_dout = 48'h0000_1111_2222;
    bus.m0_stb = 1'b1; bus.m1_stb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_done(10, who, cyc);
      chk("t2_owner", who, i % 2);
      chk("t2_period", cyc, 3);
      bus.s_dout = bus.s_dout + 48'd1;
    end
    bus.m0_stb = 1'b0; bus.m1_stb = 1'b0;
    repeat (2) @(negedge clk);

    // 3: both requesting with periodic urgent pulses; M1 runs stay bounded
    bus.m0_stb = 1'b1; bus.m1_stb = 1'b1; bus.m0_urgent = 1'b0;
    streak = 0;
    for (int k = 0; k < 10; k++) begin
      wait_done(10, who, cyc);
      chk("t3_owner", who, exp_seq3[k]);
      streak = (who == 1) ? streak + 1 : 0;
      chk("t3_m1_run_bounded", (streak <= MAX_RUN) ? 1 : 0, 1);
      bus.m0_urgent = (k % 3 == 1);
    end
    bus.m0_stb = 1'b0; bus.m1_stb = 1'b0; bus.m0_urgent = 1'b0;
    repeat (2) @(negedge clk);

    // 4: urgent M0 holds off M1 until urgency drops
    bus.m0_urgent = 1'b1; bus.m0_stb = 1'b1; bus.m1_stb = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_done(10, who, cyc);
      chk("t4_urgent_owner", who, 0);
    end
    bus.m0_urgent = 1'b0;
    wait_done(10, who, cyc);
    chk("t4_m1_after_urgent", who, 1);
    bus.m0_stb = 1'b0; bus.m1_stb = 1'b0;
    repeat (2) @(negedge clk);

    // 5: reset during WAIT abandons the transaction
    bus.m1_addr = 32'h200; bus.m1_we = 4'h3; bus.m1_din = 32'h55;
    bus.s_nak = 1'b1; bus.s_dout = 48'h7777_8888_9999; bus.m1_stb = 1'b1;
    wait_stb(10);
    repeat (2) @(negedge clk);
    rst_n = 1'b0; bus.m1_stb = 1'b0; bus.s_nak = 1'b0;
    @(negedge clk);
    chk("t5_grant",   grant,       2'b00);
    chk("t5_s_stb",   bus.s_stb,   1'b0);
    chk("t5_s_addr",  bus.s_addr,  32'h0);
    chk("t5_s_we",    bus.s_we,    4'h0);
    chk("t5_s_din",   bus.s_din,   32'h0);
    chk("t5_no_done", bus.m1_done, 1'b0);
    chk("t5_m_dout",  bus.m_dout,  48'h0);
    rst_n = 1'b1;
    bus.m0_addr = 32'h300; bus.s_dout = 48'hA5A5_0000_1234;
    bus.m0_stb = 1'b1; bus.m1_stb = 1'b1;
    wait_done(10, who, cyc);
    chk("t5_rr_reset_owner", who, 0);
    chk("t5_latency", cyc, 3);
    chk("t5_dout", bus.m_dout, 48'hA5A5_0000_1234);
    bus.m0_stb = 1'b0; bus.m1_stb = 1'b0;
    repeat (2) @(negedge clk);

`ifdef SRAM_ARB_TIMEOUT_EN
    // 6: stuck slave triggers the watchdog
    bus.s_nak = 1'b1; bus.s_dout = 48'h1111_2222_3333; bus.m1_stb = 1'b1;
    wait_stb(10);
    wait_done(400, who, cyc);
    chk("t6_owner", who, 1);
    chk("t6_abort_cycles", cyc, 256);
    chk("t6_dout_zero", bus.m_dout, 48'h0);
    chk("t6_err", err, 1'b1);
    bus.m1_stb = 1'b0; bus.s_nak = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_err_sticky", err, 1'b1);
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
